instruction_memory_ctrl: RTL and testbench

Parametrised instruction memory for the non-pipelined MIPS datapath, replacing the fixed 256x32 fetch-only store. It provides a registered fetch port with request/ready handshake, byte- or word-addressed PC with alignment and range checking, and a runtime program-load port. After every reset it runs a hardware clear sequence that fills memory with NOP (all-zero) words.

---
 rtl/instruction_memory_ctrl.sv | 138 +++++++++++++
 tb/tb_instruction_memory_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_ctrl.sv
// Instruction store with registered fetch port, program-load port
// and a post-reset clear sequence that fills every word with NOP.
module instruction_memory_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int BYTE_ADDR  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  fetch_err,
  input  logic                  prog_mode,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_err,
  output logic                  mem_ready
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int OFS = (BYTE_ADDR != 0) ? $clog2(BW) : 0;
  localparam int IW  = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'((1 << OFS) - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } state_t;

  state_t state;
  logic [IW-1:0] cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] f_idx;
  logic [ADDR_WIDTH-1:0] l_idx;
  logic                  f_bad;
  logic                  l_bad;
  logic                  fetch_go;
  logic                  load_go;
  logic                  we;
  logic [IW-1:0]         wa;
  logic [DATA_WIDTH-1:0] wd;

  always_comb begin
    f_idx    = pc >> OFS;
    l_idx    = load_addr >> OFS;
    f_bad    = ((pc & AMASK) != '0) ||
               ({1'b0, f_idx} >= DEPTH_W);
    l_bad    = ((load_addr & AMASK) != '0) ||
               ({1'b0, l_idx} >= DEPTH_W);
    fetch_go = fetch_req && fetch_ready;
    load_go  = load_valid && load_ready;
    we       = 1'b0;
    wa       = cnt;
    wd       = '0;
    if (state == CLEAR) begin
      we = 1'b1;
    end else if (load_go && !l_bad) begin
      we = 1'b1;
      wa = l_idx[IW-1:0];
      wd = load_data;
    end
  end

  // Storage carries no reset; the clear sequence owns initialisation.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      cnt         <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_ready <= 1'b0;
      load_ready  <= 1'b0;
      load_err    <= 1'b0;
      mem_ready   <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      load_err    <= 1'b0;
      if (fetch_go) begin
        instr_valid <= 1'b1;
        fetch_err   <= f_bad;
        instruction <= f_bad ? '0 : mem[f_idx[IW-1:0]];
      end
      if (load_go && l_bad) begin
        load_err <= 1'b1;
      end
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= IDLE;
            fetch_ready <= 1'b1;
            mem_ready   <= 1'b1;
          end
        end
        IDLE: begin
          if (prog_mode) begin
            state       <= LOAD;
            fetch_ready <= 1'b0;
            load_ready  <= 1'b1;
          end
        end
        LOAD: begin
          if (!prog_mode) begin
            state       <= IDLE;
            load_ready  <= 1'b0;
            fetch_ready <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Directed-vector bench for instruction_memory_ctrl: a byte-addressed
// 256x32 instance and a word-addressed 16x16 instance.
module tb_instruction_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // byte-addressed 256 x 32
  logic        a_reset = 1'b1;
  logic        a_fetch_req = 1'b0;
  logic [15:0] a_pc = '0;
  logic        a_fetch_ready;
  logic [31:0] a_instruction;
  logic        a_instr_valid;
  logic        a_fetch_err;
  logic        a_prog_mode = 1'b0;
  logic        a_load_valid = 1'b0;
  logic [15:0] a_load_addr = '0;
  logic [31:0] a_load_data = '0;
  logic        a_load_ready;
  logic        a_load_err;
  logic        a_mem_ready;

  // word-addressed 16 x 16
  logic        b_reset = 1'b1;
  logic        b_fetch_req = 1'b0;
  logic [15:0] b_pc = '0;
  logic        b_fetch_ready;
  logic [15:0] b_instruction;
  logic        b_instr_valid;
  logic        b_fetch_err;
  logic        b_prog_mode = 1'b0;
  logic        b_load_valid = 1'b0;
  logic [15:0] b_load_addr = '0;
  logic [15:0] b_load_data = '0;
  logic        b_load_ready;
  logic        b_load_err;
  logic        b_mem_ready;

  instruction_memory_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16),
    .DEPTH(256), .BYTE_ADDR(1)
  ) u_a (
    .clk(clk), .reset(a_reset),
    .fetch_req(a_fetch_req), .pc(a_pc),
    .fetch_ready(a_fetch_ready),
    .instruction(a_instruction),
    .instr_valid(a_instr_valid),
    .fetch_err(a_fetch_err),
    .prog_mode(a_prog_mode),
    .load_valid(a_load_valid),
    .load_addr(a_load_addr),
    .load_data(a_load_data),
    .load_ready(a_load_ready),
    .load_err(a_load_err),
    .mem_ready(a_mem_ready)
  );

  instruction_memory_ctrl #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16),
    .DEPTH(16), .BYTE_ADDR(0)
  ) u_b (
    .clk(clk), .reset(b_reset),
    .fetch_req(b_fetch_req), .pc(b_pc),
    .fetch_ready(b_fetch_ready),
    .instruction(b_instruction),
    .instr_valid(b_instr_valid),
    .fetch_err(b_fetch_err),
    .prog_mode(b_prog_mode),
    .load_valid(b_load_valid),
    .load_addr(b_load_addr),
    .load_data(b_load_data),
    .load_ready(b_load_ready),
    .load_err(b_load_err),
    .mem_ready(b_mem_ready)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    while (!a_mem_ready && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_b(output int n);
    n = 0;
    while (!b_mem_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    tick();
    tick();
    chk("rst_instr", a_instruction, 32'h0);
    chk("rst_valid", 32'(a_instr_valid), 32'h0);
    chk("rst_fready", 32'(a_fetch_ready), 32'h0);
    chk("rst_lready", 32'(a_load_ready), 32'h0);
    chk("rst_lerr", 32'(a_load_err), 32'h0);
    chk("rst_mready", 32'(a_mem_ready), 32'h0);

    a_reset = 1'b0;
    wait_a(n);
    chk("clear_cycles", 32'(n), 32'd256);
    chk("fready_up", 32'(a_fetch_ready), 32'h1);

    a_fetch_req = 1'b1;
    a_pc = 16'h0040;
    tick();
    a_fetch_req = 1'b0;
    chk("nop_instr", a_instruction, 32'h0);
    chk("nop_valid", 32'(a_instr_valid), 32'h1);
    chk("nop_err", 32'(a_fetch_err), 32'h0);
    tick();
    chk("valid_pulse", 32'(a_instr_valid), 32'h0);

    a_prog_mode = 1'b1;
    tick();
    chk("load_ready", 32'(a_load_ready), 32'h1);
    chk("load_fready", 32'(a_fetch_ready), 32'h0);
    a_load_valid = 1'b1;
    a_load_addr = 16'h0000;
    a_load_data = 32'h8C010020;
    tick();
    a_load_addr = 16'h0004;
    a_load_data = 32'h00221820;
    tick();
    a_load_addr = 16'h0401;
    a_load_data = 32'hFFFFFFFF;
    a_fetch_req = 1'b1;
    a_pc = 16'h0000;
    tick();
    a_load_valid = 1'b0;
    a_fetch_req = 1'b0;
    chk("load_err", 32'(a_load_err), 32'h1);
    chk("load_fetch_blk", 32'(a_instr_valid), 32'h0);
    a_load_addr = 16'h0400;
    a_load_valid = 1'b1;
    tick();
    a_load_valid = 1'b0;
    chk("load_err_rng", 32'(a_load_err), 32'h1);
    a_prog_mode = 1'b0;
    tick();
    chk("load_err_pulse", 32'(a_load_err), 32'h0);
    chk("back_idle", 32'(a_fetch_ready), 32'h1);

    a_fetch_req = 1'b1;
    a_pc = 16'h0000;
    tick();
    chk("w0_instr", a_instruction, 32'h8C010020);
    chk("w0_valid", 32'(a_instr_valid), 32'h1);
    a_pc = 16'h0004;
    tick();
    chk("w1_instr", a_instruction, 32'h00221820);
    chk("w1_valid", 32'(a_instr_valid), 32'h1);
    a_pc = 16'h0002;
    tick();
    chk("mis_err", 32'(a_fetch_err), 32'h1);
    chk("mis_instr", a_instruction, 32'h0);
    a_pc = 16'h0400;
    tick();
    a_fetch_req = 1'b0;
    chk("rng_err", 32'(a_fetch_err), 32'h1);
    chk("rng_valid", 32'(a_instr_valid), 32'h1);
    chk("rng_instr", a_instruction, 32'h0);
    tick();
    chk("err_pulse", 32'(a_fetch_err), 32'h0);

    // fetch accepted on the cycle prog_mode rises
    a_fetch_req = 1'b1;
    a_pc = 16'h0004;
    a_prog_mode = 1'b1;
    tick();
    a_fetch_req = 1'b0;
    chk("edge_fetch", a_instruction, 32'h00221820);
    chk("edge_lready", 32'(a_load_ready), 32'h1);
    a_load_valid = 1'b1;
    a_load_addr = 16'h000C;
    a_load_data = 32'hDEADBEEF;
    tick();
    a_load_valid = 1'b0;
    #2;
    a_reset = 1'b1;
    #1;
    chk("mid_lready", 32'(a_load_ready), 32'h0);
    chk("mid_mready", 32'(a_mem_ready), 32'h0);
    chk("mid_instr", a_instruction, 32'h0);
    tick();
    a_reset = 1'b0;
    wait_a(n);
    chk("clear2_cycles", 32'(n), 32'd256);
    chk("clear2_idle", 32'(a_fetch_ready), 32'h1);
    tick();
    chk("clear2_load", 32'(a_load_ready), 32'h1);
    a_prog_mode = 1'b0;
    tick();
    a_fetch_req = 1'b1;
    a_pc = 16'h000C;
    tick();
    chk("erase_w3", a_instruction, 32'h0);
    a_pc = 16'h0000;
    tick();
    a_fetch_req = 1'b0;
    chk("erase_w0", a_instruction, 32'h0);
    chk("erase_valid", 32'(a_instr_valid), 32'h1);

    b_reset = 1'b0;
    wait_b(n);
    chk("b_clear", 32'(n), 32'd16);
    b_prog_mode = 1'b1;
    tick();
    b_load_valid = 1'b1;
    b_load_addr = 16'd15;
    b_load_data = 16'hABCD;
    tick();
    b_load_valid = 1'b0;
    b_prog_mode = 1'b0;
    tick();
    b_fetch_req = 1'b1;
    b_pc = 16'd15;
    tick();
    chk("b_w15", 32'(b_instruction), 32'h0000ABCD);
    chk("b_w15_err", 32'(b_fetch_err), 32'h0);
    b_pc = 16'd16;
    tick();
    b_fetch_req = 1'b0;
    chk("b_rng_err", 32'(b_fetch_err), 32'h1);
    chk("b_rng_instr", 32'(b_instruction), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
